// File: rtl/j1_uart_io_pkg.sv
// rtl/j1_uart_io_pkg.sv - shared constants and state encodings for the J1 UART peripheral
package j1_io_pkg;

    localparam int IO_UART_DATA_BIT  = 12;
    localparam int IO_UART_STAT_BIT  = 13;
    localparam int IO_UART_IRQEN_BIT = 14;

    localparam int STAT_TX_NFULL   = 0;
    localparam int STAT_RX_NEMPTY  = 1;
    localparam int STAT_FRAME_ERR  = 2;
    localparam int STAT_RX_OVF     = 3;
    localparam int STAT_TX_IDLE    = 4;
    localparam int STAT_W          = 5;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/j1_uart_io_if.sv
// rtl/j1_uart_io_if.sv - J1 core I/O strobe bus between the core and the UART peripheral
interface j1_uart_io_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (output io_rd, output io_wr, output io_addr, output io_dout, input io_din);
    modport slave  (input io_rd, input io_wr, input io_addr, input io_dout, output io_din);
endinterface

// File: rtl/j1_uart_io_fifo.sv
// rtl/j1_uart_io_fifo.sv - small byte FIFO; a pop on empty is ignored, a push on full only lands with a pop
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/j1_uart_io.sv
// rtl/j1_uart_io.sv - memory-mapped UART on the J1 I/O bus with TX/RX FIFOs and maskable interrupt
module j1_uart_io
    import j1_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetq,
    j1_uart_io_if.slave io,
    output logic        interrupt_request,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic w_sel_data, w_sel_stat, w_sel_irqen;
    logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_idle;
    logic w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic w_rx_bit_end, w_tx_bit_end, w_ferr_set, w_ovf_set;
    logic [7:0] w_tx_dout, w_rx_dout;
    logic [STAT_W-1:0] w_status;
    logic [15:0] w_din;
    logic w_unused;

    uart_state_t     r_tx_state, r_rx_state;
    logic [CW-1:0]   r_tx_cnt, r_rx_cnt;
    logic [2:0]      r_tx_bit, r_rx_bit;
    logic [7:0]      r_tx_shift, r_rx_shift;
    logic            r_tx, r_rx_s1, r_rx_s2;
    logic            r_ferr, r_ovf;
    logic [1:0]      r_irqen;

    assign w_sel_data  = io.io_addr[IO_UART_DATA_BIT];
    assign w_sel_stat  = io.io_addr[IO_UART_STAT_BIT];
    assign w_sel_irqen = io.io_addr[IO_UART_IRQEN_BIT];
    assign w_unused    = &{1'b0, io.io_dout[15:8], io.io_addr[15], io.io_addr[11:0]};

    assign w_tx_push = io.io_wr & w_sel_data;
    assign w_rx_pop  = io.io_rd & w_sel_data & ~w_rx_empty;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .resetq(resetq), .push(w_tx_push), .pop(w_tx_pop),
        .din(io.io_dout[7:0]), .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .resetq(resetq), .push(w_rx_push), .pop(w_rx_pop),
        .din(r_rx_shift), .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
    );

    // The last stop-bit cycle doubles as IDLE so queued bytes go out without a gap.
    assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
    assign w_tx_pop     = ~w_tx_empty &
                          ((r_tx_state == UART_IDLE) | ((r_tx_state == UART_STOP) & w_tx_bit_end));
    assign w_tx_idle    = (r_tx_state == UART_IDLE) & w_tx_empty;
    assign uart_tx      = r_tx;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_shift <= w_tx_dout;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= UART_START;
        end else begin
            case (r_tx_state)
                UART_START: begin
                    r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
                    if (w_tx_bit_end) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_bit   <= '0;
                        r_tx_state <= UART_DATA;
                    end
                end
                UART_DATA: begin
                    r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= UART_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end
                end
                UART_STOP: begin
                    r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
                    if (w_tx_bit_end) r_tx_state <= UART_IDLE;
                end
                default: r_tx_cnt <= '0;
            endcase
        end
    end

    assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);
    assign w_rx_push    = (r_rx_state == UART_STOP) & w_rx_bit_end & r_rx_s2;
    assign w_ferr_set   = (r_rx_state == UART_STOP) & w_rx_bit_end & ~r_rx_s2;
    assign w_ovf_set    = w_rx_push & w_rx_full & ~w_rx_pop;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= UART_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            case (r_rx_state)
                UART_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!r_rx_s2) r_rx_state <= UART_START;
                end
                UART_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? UART_IDLE : UART_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                UART_DATA: begin
                    r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
                    if (w_rx_bit_end) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) r_rx_state <= UART_STOP;
                    end
                end
                default: begin
                    r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
                    if (w_rx_bit_end) r_rx_state <= UART_IDLE;
                end
            endcase
        end
    end

    // A new error in the same cycle as a STATUS read wins over the clear.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_irqen <= 2'b00;
        end else begin
            r_ferr <= w_ferr_set | (r_ferr & ~(io.io_rd & w_sel_stat));
            r_ovf  <= w_ovf_set  | (r_ovf  & ~(io.io_rd & w_sel_stat));
            if (io.io_wr & w_sel_irqen) r_irqen <= io.io_dout[1:0];
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_TX_NFULL]  = ~w_tx_full;
        w_status[STAT_RX_NEMPTY] = ~w_rx_empty;
        w_status[STAT_FRAME_ERR] = r_ferr;
        w_status[STAT_RX_OVF]    = r_ovf;
        w_status[STAT_TX_IDLE]   = w_tx_idle;
    end

    always_comb begin
        w_din = '0;
        if (w_sel_data & ~w_rx_empty) w_din = w_din | {8'h00, w_rx_dout};
        if (w_sel_stat)               w_din = w_din | {{(16-STAT_W){1'b0}}, w_status};
        if (w_sel_irqen)              w_din = w_din | {14'd0, r_irqen};
    end

    assign io.io_din          = w_din;
    assign interrupt_request = (r_irqen[0] & ~w_rx_empty) | (r_irqen[1] & w_tx_idle);

endmodule

// File: doc/j1_uart_io.md
# j1_uart_io

Memory-mapped UART peripheral on the J1 I/O bus. It decodes `io_rd`/`io_wr`/`io_addr` strobes from the core, buffers transmit and receive bytes in small FIFOs, and returns status and data on `io_din`. It drives the core's `interrupt_request` from maskable RX-available and TX-empty conditions. It sits directly downstream of the core's I/O port, and bridges the core to the board's USB-UART pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: entries per FIFO. Power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock for the whole block.
- `resetq`  in  1: reset, asynchronous, active-low.
- `io_rd`  in  1: core read strobe, one cycle.
- `io_wr`  in  1: core write strobe, one cycle.
- `io_addr`  in  16: I/O address.
- `io_dout`  in  16: write data; only [7:0] is used.
- `io_din`  out  16: read data.
- `interrupt_request`  out  1: level interrupt to the core.
- `uart_rx`  in  1: serial input, asynchronous to `clk`.
- `uart_tx`  out  1: serial output, idle high.

## Operation
Address decode is one-hot on `io_addr`:
- Bit 12 (0x1000) is DATA.
  - Write pushes `io_dout[7:0]` to the TX FIFO.
  - Read returns {8'h00, RX head} and pops the RX FIFO.
  - If the RX FIFO is empty, the read returns 16'h0000 and nothing is popped.
- Bit 13 (0x2000) is STATUS, read only:
  - [0] TX FIFO not full.
  - [1] RX FIFO not empty.
  - [2] sticky framing error.
  - [3] sticky RX overflow.
  - [4] transmitter fully idle (FIFO empty and shifter idle).
  - Reading STATUS clears [2] and [3].
- Bit 14 (0x4000) is IRQEN, read/write, [1:0] only:
  - [0] enables the RX-not-empty interrupt.
  - [1] enables the TX-idle interrupt.
- Multiple address bits set: every selected write takes effect; reads OR the selected sources together.
- `io_din` is combinational from `io_addr` and registered state. It is 0 when no decode bit is set.
- `interrupt_request = (irqen[0] & rx_nonempty) | (irqen[1] & tx_idle)`, combinational from registers.

TX path:
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shifter and go to START.
- START drives `uart_tx` low for one bit time.
- DATA sends 8 bits, LSB first.
- STOP drives high for one bit time, then returns to IDLE.
- `uart_tx` is a register.

RX path:
- `uart_rx` passes through a 2-flop synchronizer reset to 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: a synchronized low starts START with a half-bit counter.
- START: at mid-bit, if the line is high again, return to IDLE (glitch). Otherwise go to DATA.
- DATA samples 8 bits at bit centres.
- STOP samples at mid-bit:
  - High: push the byte.
  - Low: discard the byte and set the framing flag.
- STOP returns to IDLE right after its sample.

Boundary rules:
- DATA write with the TX FIFO full: the byte is dropped and no flag is set.
- RX push with the FIFO full and no pop in the same cycle: the byte is dropped and the overflow flag is set.
- RX push and pop in the same cycle on a full FIFO: both happen and the count is unchanged.
- Simultaneous push and pop on an empty FIFO: only the push happens.
- Pointers wrap modulo `FIFO_DEPTH`. The count is log2(`FIFO_DEPTH`)+1 bits.
- Reset mid-frame aborts both FSMs and empties both FIFOs.

Reset values:
- `uart_tx` = 1.
- `io_din` = 0 (no decode bit set, FIFOs empty).
- `interrupt_request` = 0.
- irqen = 0, sticky flags = 0, FIFOs empty, both FSMs IDLE.

## Timing
- TX latency: `io_wr` to DATA in cycle N makes the FIFO non-empty from N+1. The FSM loads at the N+1 edge, and `uart_tx` falls in cycle N+2.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back bytes add zero idle cycles: after STOP ends, IDLE pops the next byte in the same edge.
- RX: the start edge is seen 2 cycles after the pin falls (synchronizer). Sampling is at floor(`CLKS_PER_BIT`/2) past that point, then every `CLKS_PER_BIT`.
- The RX byte becomes visible in STATUS[1] the cycle after the stop-bit sample.
- Pop, flag-clear and IRQEN write take effect at the edge ending the strobe cycle.
- `io_din` in the strobe cycle shows the pre-update values.

## Structure
- Package `j1_io_pkg`:
  - address bit positions (`IO_UART_DATA_BIT` = 12, `IO_UART_STAT_BIT` = 13, `IO_UART_IRQEN_BIT` = 14);
  - STATUS bit indices;
  - UART FSM state encodings.
- Sub-module `uart_fifo` (parameterised width 8, depth `FIFO_DEPTH`), with ports `push`, `pop`, `din`, `dout`, `full`, `empty`. It is instantiated twice.
- The TX and RX FSMs stay inline in `j1_uart_io`.

## Test plan
Simulation uses `CLKS_PER_BIT` = 8.
- **Reset:** Assert `resetq` low mid-TX frame → `uart_tx` = 1 immediately; after release, STATUS reads 16'h0011.
- **Single transmit:** Write 0x55 to 0x1000 → `uart_tx` low at N+2, then bits 1,0,1,0,1,0,1,0 each 8 cycles, stop high; STATUS[4] returns to 1 after 80 cycles.
- **TX burst:** Write 6 bytes back-to-back → 5 are accepted and the 6th is dropped (4 in FIFO plus 1 in the shifter). STATUS[0] is 0 while full. 5 contiguous frames are sent with no idle gap.
- **RX receive:**
  - Drive a 0xA3 frame into `uart_rx` → STATUS[1] = 1.
  - With IRQEN = 1, `interrupt_request` = 1.
  - A read of 0x1000 returns 16'h00A3; then STATUS[1] = 0 and the IRQ drops.
- **RX errors:**
  - A frame with stop bit 0 → no byte is pushed and STATUS[2] = 1; a second STATUS read shows [2] = 0.
  - Drive 5 frames without reading → the 5th sets STATUS[3]; the FIFO holds the first 4.
- **Glitch rejection:** A 2-cycle low pulse on `uart_rx` → RX returns to IDLE; no byte and no flag.
